// File: rtl/spi_target_regfile.sv
// SPI mode-0 target exposing a bank of 8-bit registers; all SPI pins are oversampled on clk_i.
// Command byte selects read/write and a start address; the address auto-increments per data byte.
module spi_target_regfile #(
    parameter int          NumRegs    = 16,
    parameter int          SyncStages = 2,
    parameter logic [7:0]  IdByte     = 8'hC5,
    parameter logic [7:0]  RstVal     = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spi_sck_i,
    input  logic                 spi_csb_i,
    input  logic                 spi_sd_i,
    output logic                 spi_sd_o,
    output logic                 spi_sd_oe_o,
    output logic [NumRegs*8-1:0] regs_o,
    output logic                 wr_pulse_o,
    output logic [6:0]           wr_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SyncStages-1:0] sck_sync, csb_sync, sd_sync;
    logic                  sck_d, csb_d;
    logic                  sck_s, csb_s, sd_s;
    logic                  sck_rise, sck_fall, csb_fall;

    logic [2:0] cnt_q;
    logic       seen_rise_q;
    logic       load_pend_q;
    logic       is_read_q;
    logic [6:0] addr_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] regs_q [NumRegs];

    logic       active;
    logic       bit_rise;
    logic       bit_fall;
    logic       byte_end;
    logic       addr_ok;
    logic       wr_en;
    logic [7:0] rx_byte;
    logic [7:0] rd_data;
    logic [7:0] next_byte;

    // Input synchronizers plus one extra flop per control line for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
            csb_d    <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SyncStages-2:0], spi_sck_i};
            csb_sync <= {csb_sync[SyncStages-2:0], spi_csb_i};
            sd_sync  <= {sd_sync[SyncStages-2:0], spi_sd_i};
            sck_d    <= sck_sync[SyncStages-1];
            csb_d    <= csb_sync[SyncStages-1];
        end
    end

    assign sck_s    = sck_sync[SyncStages-1];
    assign csb_s    = csb_sync[SyncStages-1];
    assign sd_s     = sd_sync[SyncStages-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csb_fall = ~csb_s & csb_d;

    assign active   = (state_q != IDLE);
    // A high CSB masks any coincident SCK edge, so that bit is dropped
    assign bit_rise = active & ~csb_s & sck_rise;
    assign bit_fall = active & ~csb_s & sck_fall & seen_rise_q;
    assign byte_end = bit_rise & (cnt_q == 3'd7);
    assign rx_byte  = {rx_q[6:0], sd_s};
    assign addr_ok  = ({1'b0, addr_q} < 8'(NumRegs));
    assign wr_en    = byte_end & (state_q == DATA) & ~is_read_q & addr_ok;

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NumRegs; k++) begin
            if (addr_q == 7'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    assign next_byte = (state_q == DATA && is_read_q && addr_ok) ? rd_data : 8'h00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (csb_fall) state_d = CMD;
                CMD:     if (byte_end) state_d = DATA;
                DATA:    state_d = DATA;
                default: state_d = IDLE;
            endcase
        end
    end

    // Bit counter, address pointer and byte-boundary bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= 3'd0;
            seen_rise_q <= 1'b0;
            load_pend_q <= 1'b0;
            is_read_q   <= 1'b0;
            addr_q      <= 7'd0;
        end else if (csb_s || !active) begin
            cnt_q       <= 3'd0;
            seen_rise_q <= 1'b0;
            load_pend_q <= 1'b0;
        end else if (bit_rise) begin
            cnt_q       <= cnt_q + 3'd1;
            seen_rise_q <= 1'b1;
            if (cnt_q == 3'd7) begin
                load_pend_q <= 1'b1;
                if (state_q == CMD) begin
                    is_read_q <= rx_byte[7];
                    addr_q    <= rx_byte[6:0];
                end else begin
                    addr_q    <= addr_q + 7'd1;
                end
            end
        end else if (bit_fall) begin
            load_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bit_rise) begin
            rx_q <= rx_byte;
        end
    end

    // MISO shifter; the falling edge after a byte boundary reloads instead of shifting
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && !csb_s && csb_fall) begin
            tx_q <= IdByte;
        end else if (bit_fall) begin
            tx_q <= load_pend_q ? next_byte : {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_pulse_o <= 1'b0;
            wr_addr_o  <= 7'd0;
        end else begin
            wr_pulse_o <= wr_en;
            if (wr_en) begin
                wr_addr_o <= addr_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumRegs; k++) begin
                regs_q[k] <= RstVal;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NumRegs; k++) begin
                if (addr_q == 7'(k)) begin
                    regs_q[k] <= rx_byte;
                end
            end
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : g_regs_out
        assign regs_o[8*g +: 8] = regs_q[g];
    end

    assign spi_sd_oe_o = active;
    assign spi_sd_o    = active & tx_q[7];

endmodule

// File: tb/tb_spi_target_regfile.sv
// Bench for spi_target_regfile: directed and randomized SPI transactions against a register-bank model.
module tb_spi_target_regfile;

    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sck;
    logic          csb;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic [NR*8-1:0] regs;
    logic          wr_pulse;
    logic [6:0]    wr_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [NR];
    int         wr_seen [$];
    logic [7:0] mbytes [8];
    logic [7:0] sbytes [8];

    spi_target_regfile #(
        .NumRegs   (NR),
        .SyncStages(2),
        .IdByte    (8'hC5),
        .RstVal    (8'h00)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_sck_i  (sck),
        .spi_csb_i  (csb),
        .spi_sd_i   (mosi),
        .spi_sd_o   (miso),
        .spi_sd_oe_o(miso_oe),
        .regs_o     (regs),
        .wr_pulse_o (wr_pulse),
        .wr_addr_o  (wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_seen.push_back(int'(wr_addr));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[8*k +: 8] = model[k];
        return v;
    endfunction

    // Shift nb bits of v out MSB first at an SCK period of 8 clk cycles; capture MISO before each rise
    task automatic send_byte(input logic [7:0] v, input int nb, output logic [7:0] got);
        got = 8'h00;
        for (int b = 0; b < nb; b++) begin
            mosi = v[7-b];
            wait_clk(4);
            got[7-b] = miso;
            if (b == 0) check("oe_during_xfer", 128'(miso_oe), 128'd1);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
    endtask

    // Runs mbytes[0..nfull-1] plus an optional partial byte, then checks against the model
    task automatic xfer(input int nfull, input int extra);
        logic [7:0] exp_miso [8];
        int         exp_wr [$];
        int         a;
        logic       rd;
        logic [7:0] got;

        rd = mbytes[0][7];
        a  = int'(mbytes[0][6:0]);
        exp_miso[0] = 8'hC5;
        for (int i = 1; i < nfull; i++) begin
            if (rd) begin
                exp_miso[i] = (a < NR) ? model[a] : 8'h00;
            end else begin
                exp_miso[i] = 8'h00;
                if (a < NR) begin
                    model[a] = mbytes[i];
                    exp_wr.push_back(a);
                end
            end
            a = (a + 1) % 128;
        end

        wr_seen.delete();
        csb = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nfull; i++) begin
            send_byte(mbytes[i], 8, got);
            sbytes[i] = got;
        end
        if (extra > 0) send_byte(mbytes[nfull], extra, got);
        wait_clk(4);
        csb = 1'b1;
        wait_clk(8);

        for (int i = 0; i < nfull; i++) check("miso_byte", 128'(sbytes[i]), 128'(exp_miso[i]));
        check("oe_idle", 128'(miso_oe), 128'd0);
        check("miso_idle", 128'(miso), 128'd0);
        check("wr_pulse_count", 128'(wr_seen.size()), 128'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_seen.size(); i++)
            check("wr_addr", 128'(wr_seen[i]), 128'(exp_wr[i]));
        check("regs", regs, model_vec());
    endtask

    initial begin
        logic [7:0] got;
        int nf;
        int ex;

        rst  = 1'b1;
        sck  = 1'b0;
        csb  = 1'b1;
        mosi = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = 8'h00;
        wait_clk(5);
        check("rst_oe", 128'(miso_oe), 128'd0);
        check("rst_miso", 128'(miso), 128'd0);
        rst = 1'b0;
        wait_clk(10);
        check("reset_regs", regs, model_vec());
        check("reset_wr_pulse", 128'(wr_pulse), 128'd0);
        check("reset_wr_addr", 128'(wr_addr), 128'd0);
        check("reset_no_pulses", 128'(wr_seen.size()), 128'd0);

        // Write 0x03: AB, CD
        mbytes[0] = 8'h03; mbytes[1] = 8'hAB; mbytes[2] = 8'hCD;
        xfer(3, 0);

        // Read back from 0x03
        mbytes[0] = 8'h83; mbytes[1] = 8'h00; mbytes[2] = 8'h00;
        xfer(3, 0);

        // Write across the end of the bank, then read it back
        mbytes[0] = 8'h0F; mbytes[1] = 8'h11; mbytes[2] = 8'h22;
        xfer(3, 0);
        mbytes[0] = 8'h8F; mbytes[1] = 8'h5A; mbytes[2] = 8'hA5;
        xfer(3, 0);

        // Abort after 5 bits of a data byte to reg 2
        mbytes[0] = 8'h02; mbytes[1] = 8'h5A;
        xfer(1, 5);

        // Reset in the middle of a data byte write to reg 2
        wr_seen.delete();
        csb = 1'b0;
        wait_clk(4);
        send_byte(8'h02, 8, got);
        send_byte(8'hE7, 4, got);
        rst = 1'b1;
        csb = 1'b1;
        sck = 1'b0;
        wait_clk(3);
        for (int k = 0; k < NR; k++) model[k] = 8'h00;
        check("midrst_regs", regs, model_vec());
        check("midrst_oe", 128'(miso_oe), 128'd0);
        check("midrst_miso", 128'(miso), 128'd0);
        check("midrst_wr_pulse", 128'(wr_pulse), 128'd0);
        check("midrst_wr_addr", 128'(wr_addr), 128'd0);
        rst = 1'b0;
        wait_clk(6);
        check("midrst_no_pulses", 128'(wr_seen.size()), 128'd0);

        mbytes[0] = 8'h01; mbytes[1] = 8'h3C; mbytes[2] = 8'hC3;
        xfer(3, 0);
        mbytes[0] = 8'h81; mbytes[1] = 8'h00; mbytes[2] = 8'h00;
        xfer(3, 0);

        // Randomized transactions, including address wrap from 127 and partial trailing bytes
        for (int t = 0; t < 24; t++) begin
            logic [6:0] sa;
            if ($urandom_range(0, 3) == 0) sa = 7'(125 + $urandom_range(0, 2));
            else                           sa = 7'($urandom_range(0, 19));
            mbytes[0] = {1'($urandom_range(0, 1)), sa};
            nf = $urandom_range(1, 5);
            for (int i = 1; i < 8; i++) mbytes[i] = 8'($urandom);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            xfer(nf, ex);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
